conv_line_feeder: RTL and testbench
===================================

CONV_LINE_FEEDER -- requirements
Module: conv_line_feeder

Interface
REQ-001 SHALL have parameter I_X, default 8, pixel width (signed).
REQ-002 SHALL have parameter I_W, default 8, weight width (signed).
REQ-003 SHALL have parameter I_PSUM, default 16, partial-sum width (signed).
REQ-004 SHALL have parameter TAPS, default 5, taps per window; legal range 2..8.
REQ-005 SHALL have port i_clk, input, 1, single clock; all logic on its rising edge.
REQ-006 SHALL have port i_rst_n, input, 1, asynchronous active-low reset.
REQ-007 SHALL have weight-write ports: i_w_wr input 1, strobe; i_w_addr input 3, tap index; i_w_data input I_W, weight.
REQ-008 SHALL have port i_start input 1, and port i_len input 8, pixel count for the row.
REQ-009 SHALL have pixel-input ports: i_x_valid input 1; i_x_data input I_X; i_psum input I_PSUM, sampled with the pixel; o_x_ready output 1.
REQ-010 SHALL have MAC-side outputs to the convolution line: o_x I_X; o_w I_W; o_psum I_PSUM; o_valid 1; o_first 1 (tap 0); o_last 1 (tap TAPS-1).
REQ-011 SHALL have status outputs o_busy 1, o_done 1 (one-cycle pulse) and o_err 1 (one-cycle pulse).

Function
REQ-012 SHALL hold weight bank w[0..TAPS-1]; write on i_w_wr only in IDLE with i_w_addr<TAPS; other writes ignored.
REQ-013 SHALL hold pixel window win[0..TAPS-1]; each accept (i_x_valid & o_x_ready) shifts in i_x_data; win[TAPS-1] is the oldest pixel.
REQ-014 SHALL implement states IDLE, FILL, EMIT, WAIT, DONE; o_busy=1 in every state except IDLE.
REQ-015 IDLE: on i_start with i_len>=TAPS, latch i_len, clear counters, go to FILL; with i_len<TAPS, pulse o_err, stay in IDLE.
REQ-016 FILL: o_x_ready=1; after TAPS accepts, go to EMIT with tap=0.
REQ-017 EMIT: o_valid=1; tap advances by 1 per cycle; o_x=win[TAPS-1-tap]; o_w=w[tap]; o_first=(tap==0); o_last=(tap==TAPS-1).
REQ-018 o_psum SHALL equal the i_psum captured with the window's newest pixel when tap==0, else 0.
REQ-019 EMIT, tap==TAPS-1: o_x_ready=1 only if unaccepted pixels remain.
- If accepted: next cycle is EMIT tap 0 on the new window (back-to-back).
- If not accepted with pixels remaining: go to WAIT.
- If no pixels remain: go to DONE.
REQ-020 WAIT: o_x_ready=1, o_valid=0; on accept go to EMIT tap 0.
REQ-021 DONE: pulse o_done for one cycle, then return to IDLE.
REQ-022 Outputs SHALL be driven only from registered state, with no combinational input-to-output path except o_x_ready, which depends on state only.
REQ-023 Latency: the accept that completes a window in cycle t SHALL give tap 0 on the outputs in cycle t+1.
REQ-024 Window count: a row of L pixels SHALL produce exactly L-TAPS+1 windows, i.e. (L-TAPS+1)*TAPS o_valid cycles.
REQ-025 i_start outside IDLE SHALL be ignored; o_valid=0 forces o_x, o_w and o_psum to 0.

Reset
REQ-026 While i_rst_n=0, all of the following SHALL be 0, independent of i_clk: state=IDLE, w[], win[], counters, and every output.
REQ-027 Reset asserted mid-row SHALL abort the row, with no o_done pulse.

Configuration
REQ-028 With CONV_FEED_PSUM_EN defined, psum forwarding SHALL follow REQ-018.
REQ-029 Without CONV_FEED_PSUM_EN, o_psum SHALL be constant 0, i_psum unused and no psum storage built.

Verification
REQ-030 Load w=50,5,15,50,50; start L=7; stream 100,10,100,20,100,10,16 with no gaps. Required: 3 windows, 15 o_valid cycles. Window 1 is x=100,10,100,20,100 with w=50,5,15,50,50. Window 3 is x=100,20,100,10,16. One o_done pulse follows.
REQ-031 Hold i_x_valid low for 3 cycles after window 1's last tap. Required: WAIT for 3 cycles with o_valid=0, then window 2 tap 0 one cycle after the accept.
REQ-032 Start with L=4. Required: o_err pulses, o_busy stays 0, no o_valid.
REQ-033 Write w[2]=-7 while busy, and write addr=6 in IDLE. Required: both writes ignored and weights unchanged on the next row.
REQ-034 Drive i_rst_n low during window 2 tap 2. Required: all outputs 0 immediately, state IDLE, no o_done. A fresh row afterwards runs correctly.
REQ-035 Apply i_psum=1234 with pixel 5 of the L=7 row, both with and without CONV_FEED_PSUM_EN. Required: o_psum=1234 on window 1 tap 0 with the macro defined, and 0 on all cycles without it.

Source files
------------

// File: rtl/conv_line_feeder.sv
// Convolution line feeder: holds a TAPS-deep pixel window and a weight bank, and
// serialises each window to a MAC line one tap per cycle (oldest pixel first).
// Optional feature macro: CONV_FEED_PSUM_EN enables forwarding of the partial sum
// captured with each window's newest pixel on tap 0. Without it, o_psum is tied to 0.
module conv_line_feeder #(
  parameter int unsigned I_X    = 8,
  parameter int unsigned I_W    = 8,
  parameter int unsigned I_PSUM = 16,
  parameter int unsigned TAPS   = 5
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_w_wr,
  input  logic [2:0]        i_w_addr,
  input  logic [I_W-1:0]    i_w_data,
  input  logic              i_start,
  input  logic [7:0]        i_len,
  input  logic              i_x_valid,
  input  logic [I_X-1:0]    i_x_data,
  input  logic [I_PSUM-1:0] i_psum,
  output logic              o_x_ready,
  output logic [I_X-1:0]    o_x,
  output logic [I_W-1:0]    o_w,
  output logic [I_PSUM-1:0] o_psum,
  output logic              o_valid,
  output logic              o_first,
  output logic              o_last,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  localparam int unsigned TapW = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam logic [TapW-1:0] LastTap = TapW'(TAPS - 1);

  typedef enum logic [2:0] {StIdle, StFill, StEmit, StWait, StDone} state_e;

  state_e          state_q, state_d;
  logic [TapW-1:0] tap_q, tap_d;
  logic [7:0]      pix_cnt_q, pix_cnt_d;
  logic [7:0]      len_q, len_d;
  logic [I_W-1:0]  w_q [TAPS];
  logic [I_W-1:0]  w_d [TAPS];
  logic [I_X-1:0]  win_q [TAPS];
  logic [I_X-1:0]  win_d [TAPS];

  logic [I_X-1:0]  x_q, x_d;
  logic [I_W-1:0]  wo_q, wo_d;
  logic            valid_q, valid_d;
  logic            first_q, first_d;
  logic            last_q, last_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            err_q, err_d;
  logic            accept;

  assign accept = i_x_valid & o_x_ready;

  // Ready is a function of registered state only (never of i_x_valid).
  always_comb begin
    o_x_ready = 1'b0;
    unique case (state_q)
      StFill, StWait: o_x_ready = 1'b1;
      StEmit:         o_x_ready = (tap_q == LastTap) && (pix_cnt_q < len_q);
      default:        o_x_ready = 1'b0;
    endcase
  end

  // Next-state: window shift, weight writes, counters and FSM transitions.
  always_comb begin
    state_d   = state_q;
    tap_d     = tap_q;
    pix_cnt_d = pix_cnt_q;
    len_d     = len_q;
    w_d       = w_q;
    win_d     = win_q;
    err_d     = 1'b0;

    if (accept) begin
      win_d[0] = i_x_data;
      for (int i = 1; i < int'(TAPS); i++) win_d[i] = win_q[i-1];
      pix_cnt_d = pix_cnt_q + 8'd1;
    end

    unique case (state_q)
      StIdle: begin
        if (i_w_wr) begin
          for (int i = 0; i < int'(TAPS); i++) begin
            if (32'(i_w_addr) == 32'(i)) w_d[i] = i_w_data;
          end
        end
        if (i_start) begin
          if (32'(i_len) >= TAPS) begin
            len_d     = i_len;
            pix_cnt_d = '0;
            tap_d     = '0;
            state_d   = StFill;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StFill: begin
        if (accept && (32'(pix_cnt_q) + 32'd1 == TAPS)) begin
          tap_d   = '0;
          state_d = StEmit;
        end
      end
      StEmit: begin
        if (tap_q != LastTap) begin
          tap_d = tap_q + TapW'(1);
        end else begin
          tap_d = '0;
          if (accept)                 state_d = StEmit;
          else if (pix_cnt_q < len_q) state_d = StWait;
          else                        state_d = StDone;
        end
      end
      StWait: begin
        if (accept) begin
          tap_d   = '0;
          state_d = StEmit;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output registers are loaded from next-state so tap 0 appears the cycle after the accept.
  always_comb begin
    valid_d = (state_d == StEmit);
    x_d     = valid_d ? win_d[LastTap - tap_d] : '0;
    wo_d    = valid_d ? w_d[tap_d] : '0;
    first_d = valid_d && (tap_d == '0);
    last_d  = valid_d && (tap_d == LastTap);
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
  end

`ifdef CONV_FEED_PSUM_EN
  logic [I_PSUM-1:0] psum_q, psum_d, opsum_q, opsum_d;

  // Keep the psum of the newest pixel; present it only on tap 0.
  always_comb begin
    psum_d  = accept ? i_psum : psum_q;
    opsum_d = first_d ? psum_d : '0;
  end

  // Psum storage.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      psum_q  <= '0;
      opsum_q <= '0;
    end else begin
      psum_q  <= psum_d;
      opsum_q <= opsum_d;
    end
  end

  assign o_psum = opsum_q;
`else
  logic unused_psum;
  assign unused_psum = ^i_psum;
  assign o_psum      = '0;
`endif

  // All state and registered outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= StIdle;
      tap_q     <= '0;
      pix_cnt_q <= '0;
      len_q     <= '0;
      w_q       <= '{default: '0};
      win_q     <= '{default: '0};
      x_q       <= '0;
      wo_q      <= '0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      tap_q     <= tap_d;
      pix_cnt_q <= pix_cnt_d;
      len_q     <= len_d;
      w_q       <= w_d;
      win_q     <= win_d;
      x_q       <= x_d;
      wo_q      <= wo_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign o_x     = x_q;
  assign o_w     = wo_q;
  assign o_valid = valid_q;
  assign o_first = first_q;
  assign o_last  = last_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

endmodule

// File: tb/tb_conv_line_feeder.sv
// Scoreboard bench for conv_line_feeder (TAPS=5). Stimulus pushes expected taps into
// exp_q; the negedge monitor pops and compares on every o_valid cycle.
module tb_conv_line_feeder;

  logic        i_clk = 1'b0;
  logic        i_rst_n = 1'b0;
  logic        i_w_wr = 1'b0;
  logic [2:0]  i_w_addr = '0;
  logic [7:0]  i_w_data = '0;
  logic        i_start = 1'b0;
  logic [7:0]  i_len = '0;
  logic        i_x_valid = 1'b0;
  logic [7:0]  i_x_data = '0;
  logic [15:0] i_psum = '0;
  logic        o_x_ready;
  logic [7:0]  o_x;
  logic [7:0]  o_w;
  logic [15:0] o_psum;
  logic        o_valid, o_first, o_last, o_busy, o_done, o_err;

  conv_line_feeder #(.I_X(8), .I_W(8), .I_PSUM(16), .TAPS(5)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_w_wr(i_w_wr), .i_w_addr(i_w_addr),
    .i_w_data(i_w_data), .i_start(i_start), .i_len(i_len), .i_x_valid(i_x_valid),
    .i_x_data(i_x_data), .i_psum(i_psum), .o_x_ready(o_x_ready), .o_x(o_x), .o_w(o_w),
    .o_psum(o_psum), .o_valid(o_valid), .o_first(o_first), .o_last(o_last),
    .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int valid_cnt = 0;
  int gap_cnt = 0;
  bit gap_on = 1'b0;
  int gaps_q[$];
  logic [33:0] exp_q[$];

  int wexp[5] = '{50, 5, 15, 50, 50};
  int pix1[8] = '{100, 10, 100, 20, 100, 10, 16, 0};
  int ps1[8]  = '{1000, 1001, 1002, 1003, 1234, 1005, 1006, 0};
  int pix2[8] = '{1, -2, 3, -4, 5, 0, 0, 0};
  int ps2[8]  = '{11, 12, 13, 14, 777, 0, 0, 0};

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", name, got, want, $time);
    end
  endtask

  // Expected {x, w, psum, first, last} for each tap of each window, up to limit entries.
  task automatic push_row(input int pix[8], input int ps[8], input int len, input int limit);
    int n = 0;
    logic [15:0] pv;
    for (int k = 0; k <= len - 5; k++) begin
      for (int t = 0; t < 5; t++) begin
`ifdef CONV_FEED_PSUM_EN
        pv = (t == 0) ? 16'(ps[k+4]) : 16'd0;
`else
        pv = 16'd0;
`endif
        if (n < limit) exp_q.push_back({8'(pix[k+t]), 8'(wexp[t]), pv, t == 0, t == 4});
        n++;
      end
    end
  endtask

  // Monitor: pop and compare on o_valid, check zeroed datapath otherwise, measure gaps.
  always @(negedge i_clk) begin
    logic [33:0] e;
    if (o_done) done_cnt++;
    if (o_err) err_cnt++;
    if (o_valid) begin
      valid_cnt++;
      if (o_first && gap_on) gaps_q.push_back(gap_cnt);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_valid: got x=%0d w=%0d want none at %0t", o_x, o_w, $time);
      end else begin
        e = exp_q.pop_front();
        chk("tap", 64'({o_x, o_w, o_psum, o_first, o_last}), 64'(e));
      end
      if (o_last) begin
        gap_on  = 1'b1;
        gap_cnt = 0;
      end
    end else begin
      if (gap_on) gap_cnt++;
      chk("idle_zero", 64'({o_x, o_w, o_psum, o_first, o_last}), 64'd0);
    end
  end

  task automatic send_pix(input int d, input int p);
    int n = 0;
    i_x_valid = 1'b1;
    i_x_data  = 8'(d);
    i_psum    = 16'(p);
    while (!o_x_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("accept_ready", 64'(o_x_ready), 64'd1);
    if (o_x_ready) @(negedge i_clk);
    i_x_valid = 1'b0;
  endtask

  task automatic start_row(input int len);
    i_len   = 8'(len);
    i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
  endtask

  task automatic wait_done(input int base);
    int n = 0;
    while (done_cnt == base && n < 200) begin
      @(negedge i_clk);
      n++;
    end
    repeat (3) @(negedge i_clk);
    chk("done_pulses", 64'(done_cnt - base), 64'd1);
  endtask

  int vbase, dbase, ebase;

  initial begin
    // Reset values, asynchronous (no clock edge yet).
    #3;
    chk("reset_outputs", 64'({o_x, o_w, o_psum, o_valid, o_first, o_last, o_busy, o_done,
                             o_err, o_x_ready}), 64'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Weight load, then an out-of-range address that must be dropped.
    for (int t = 0; t < 5; t++) begin
      i_w_wr = 1'b1; i_w_addr = 3'(t); i_w_data = 8'(wexp[t]);
      @(negedge i_clk);
    end
    i_w_addr = 3'd6; i_w_data = 8'd99;
    @(negedge i_clk);
    i_w_wr = 1'b0;

    // Row L=7 with a 3-cycle WAIT before pixel 6, and a busy weight write.
    vbase = valid_cnt; dbase = done_cnt;
    gaps_q.delete();
    push_row(pix1, ps1, 7, 99);
    start_row(7);
    chk("busy_fill", 64'(o_busy), 64'd1);
    for (int i = 0; i < 5; i++) send_pix(pix1[i], ps1[i]);
    chk("tap0_latency", 64'({o_valid, o_first}), 64'b11);
    i_w_wr = 1'b1; i_w_addr = 3'd2; i_w_data = 8'hF9;
    @(negedge i_clk);
    i_w_wr = 1'b0;
    repeat (6) @(negedge i_clk);
    send_pix(pix1[5], ps1[5]);
    send_pix(pix1[6], ps1[6]);
    wait_done(dbase);
    chk("row1_valid_cycles", 64'(valid_cnt - vbase), 64'd15);
    chk("row1_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("row1_gap_count", 64'(gaps_q.size()), 64'd2);
    if (gaps_q.size() == 2) begin
      chk("wait_cycles", 64'(gaps_q[0]), 64'd3);
      chk("back_to_back", 64'(gaps_q[1]), 64'd0);
    end
    chk("idle_after_done", 64'({o_busy, o_done}), 64'd0);

    // Too-short row: error pulse, never busy, no output.
    vbase = valid_cnt; ebase = err_cnt;
    i_len = 8'd4; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    chk("err_pulse", 64'({o_err, o_busy}), 64'b10);
    @(negedge i_clk);
    chk("err_one_cycle", 64'({o_err, o_busy}), 64'b00);
    repeat (4) @(negedge i_clk);
    chk("err_no_valid", 64'(valid_cnt - vbase), 64'd0);
    chk("err_count", 64'(err_cnt - ebase), 64'd1);

    // Boundary row L=TAPS: exactly one window.
    vbase = valid_cnt; dbase = done_cnt;
    push_row(pix2, ps2, 5, 99);
    start_row(5);
    for (int i = 0; i < 5; i++) send_pix(pix2[i], ps2[i]);
    wait_done(dbase);
    chk("rowmin_valid_cycles", 64'(valid_cnt - vbase), 64'd5);

    // Reset during window 2 tap 2.
    dbase = done_cnt;
    push_row(pix1, ps1, 7, 8);
    start_row(7);
    for (int i = 0; i < 6; i++) send_pix(pix1[i], ps1[i]);
    repeat (2) @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    chk("midrow_reset_outputs", 64'({o_x, o_w, o_psum, o_valid, o_first, o_last, o_busy,
                                    o_done, o_err, o_x_ready}), 64'd0);
    repeat (3) @(negedge i_clk);
    i_rst_n = 1'b1;
    repeat (3) @(negedge i_clk);
    chk("no_done_after_abort", 64'(done_cnt - dbase), 64'd0);
    chk("abort_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("abort_idle", 64'(o_busy), 64'd0);

    // Fresh row after reset; weights reloaded (reset clears the bank).
    for (int t = 0; t < 5; t++) begin
      i_w_wr = 1'b1; i_w_addr = 3'(t); i_w_data = 8'(wexp[t]);
      @(negedge i_clk);
    end
    i_w_wr = 1'b0;
    vbase = valid_cnt; dbase = done_cnt;
    push_row(pix1, ps1, 7, 99);
    start_row(7);
    for (int i = 0; i < 7; i++) send_pix(pix1[i], ps1[i]);
    wait_done(dbase);
    chk("row3_valid_cycles", 64'(valid_cnt - vbase), 64'd15);
    chk("row3_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
